cv32e40p_cg_ctrl: RTL and testbench
===================================

# cv32e40p_cg_ctrl

Clock-enable controller driving the `en_i` input of `cv32e40p_clock_gate` in the core top level.
- Runs on the ungated clock.
- Holds the core clock off until fetch is enabled.
- On WFI, drains in-flight fetch and LSU activity, then gates the core clock.
- On a wake request, restores the clock before the core resumes.
- Also exports core sleep status and a saturating sleep-cycle counter for performance monitoring.

## Interface
- `DRAIN_CYCLES`, default 2: consecutive non-busy cycles required before gating. Legal range ≥ 1.
- `WAKE_CYCLES`, default 1: cycles spent in WAKE, with clock enabled, before returning to RUN. Legal range ≥ 1.
- `CNT_W`, default 32: width of the sleep-cycle counter.
- `clk_ungated_i`, in, 1: ungated clock. Everything here is clocked by it.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `fetch_enable_i`, in, 1: level request to start the core.
- `wfi_req_i`, in, 1: level. Core is stalled on WFI and requests sleep.
- `wake_i`, in, 1: level. Enabled pending interrupt or debug request, combined upstream.
- `if_busy_i`, in, 1: instruction fetch has outstanding transactions.
- `lsu_busy_i`, in, 1: LSU has outstanding transactions.
- `clock_en_o`, out, 1: to the clock gate's `en_i`. Reset 0.
- `fetch_enable_o`, out, 1: sticky fetch enable to the core. Reset 0.
- `core_sleep_o`, out, 1: core clock is gated. Reset 0.
- `sleep_cycles_o`, out, `CNT_W`: number of cycles spent in SLEEP, saturating. Reset 0.

## Operation
- States: BOOT (reset), RUN, DRAIN, SLEEP, WAKE.
- BOOT:
  - `clock_en_o`=0.
  - `fetch_enable_i`=1 → RUN.
  - `fetch_enable_o` is set on the same edge and stays 1 until reset. Later deassertion of `fetch_enable_i` is ignored.
- RUN:
  - `clock_en_o`=1.
  - `wfi_req_i`=1 and `wake_i`=0 → DRAIN, with the quiet counter cleared.
  - `wfi_req_i`=1 and `wake_i`=1 → stay in RUN.
- DRAIN:
  - `clock_en_o`=1.
  - Quiet counter (width `$clog2(DRAIN_CYCLES+1)`) increments on each cycle with `if_busy_i`=0 and `lsu_busy_i`=0. Any busy cycle resets it to 0.
  - Counter reaching `DRAIN_CYCLES` → SLEEP.
  - Priority: `wake_i`=1 or `wfi_req_i`=0 → RUN. This overrides drain completion in the same cycle.
- SLEEP:
  - `clock_en_o`=0, `core_sleep_o`=1.
  - `sleep_cycles_o` increments every cycle and holds at all-ones.
  - `wake_i`=1 → WAKE.
  - Busy inputs and `wfi_req_i` are ignored.
- WAKE:
  - `clock_en_o`=1, `core_sleep_o`=0.
  - Wake counter runs for `WAKE_CYCLES` cycles, then → RUN.
  - `wake_i` deasserting during WAKE is ignored.
- All outputs are driven directly from flops. `clock_en_o` must be glitch-free; no combinational path from inputs to outputs.
- `sleep_cycles_o` is cleared only by reset.

## Timing
- `fetch_enable_i` high in cycle N (BOOT) → `clock_en_o` and `fetch_enable_o` high in cycle N+1.
- Gating latency: `wfi_req_i` high in cycle N, with no busy and no wake → DRAIN in N+1 → SLEEP in N+1+`DRAIN_CYCLES`. `clock_en_o` falls in that same cycle.
- Wake latency: `wake_i` high in cycle N (SLEEP) → `clock_en_o`=1 and `core_sleep_o`=0 in N+1 → RUN in N+1+`WAKE_CYCLES`.
- `sleep_cycles_o` equals the number of cycles the state register has held SLEEP.
- Reset asserted at any time, including in SLEEP or mid-DRAIN: state, outputs and counters take their reset values asynchronously. The FSM resumes from BOOT after release.

## Structure
- `cg_ctrl_state_e` (BOOT, RUN, DRAIN, SLEEP, WAKE) belongs in `cv32e40p_pkg`.
- No sub-module: one FSM plus three counters (quiet, wake, sleep).
- Instantiated beside `cv32e40p_clock_gate` in the core top. `scan_cg_en_i` goes straight to the gate, not through this block.

## Test plan
- Reset, then `fetch_enable_i` pulse at cycle 5 → `clock_en_o`=1 and `fetch_enable_o`=1 from cycle 6. Dropping `fetch_enable_i` at cycle 10 leaves both at 1.
- `wfi_req_i`=1 in RUN with `lsu_busy_i`=1 for 3 cycles, then 0 (`DRAIN_CYCLES`=2) → `clock_en_o` falls exactly 2 cycles after `lsu_busy_i` drops; `core_sleep_o`=1.
- Sleep for 10 cycles, then `wake_i`=1 → `clock_en_o`=1 next cycle, RUN after `WAKE_CYCLES`, `sleep_cycles_o`=10.
- In DRAIN, `wake_i`=1 on the cycle the quiet counter would complete → RUN; `clock_en_o` never drops.
- `CNT_W`=4: sleep for 20 cycles → `sleep_cycles_o` saturates at 15.
- `rst_n` asserted mid-SLEEP → all outputs 0 immediately; state BOOT after release.

Source files
------------

// File: rtl/cv32e40p_pkg.sv
// Shared types for the cv32e40p core slice: clock-gate controller states.
package cv32e40p_pkg;

   // Clock-gate controller FSM states.
   // BOOT is the reset state and must stay encoded as zero.
   typedef enum logic [2:0] {
      CG_BOOT  = 3'd0,
      CG_RUN   = 3'd1,
      CG_DRAIN = 3'd2,
      CG_SLEEP = 3'd3,
      CG_WAKE  = 3'd4
   } cg_ctrl_state_e;

endpackage

// File: rtl/cv32e40p_cg_ctrl.sv
// Clock-enable controller feeding en_i of cv32e40p_clock_gate.
// Runs on the ungated clock. Keeps the core clock off until fetch is enabled,
// drains fetch/LSU traffic before gating on WFI, and restores the clock on wake.
// Every output comes straight from a flop so the clock-gate enable is glitch-free.
module cv32e40p_cg_ctrl
   import cv32e40p_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter int unsigned WAKE_CYCLES  = 1,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk_ungated_i,
   input  logic             rst_n,
   input  logic             fetch_enable_i,
   input  logic             wfi_req_i,
   input  logic             wake_i,
   input  logic             if_busy_i,
   input  logic             lsu_busy_i,
   output logic             clock_en_o,
   output logic             fetch_enable_o,
   output logic             core_sleep_o,
   output logic [CNT_W-1:0] sleep_cycles_o
);

   localparam int unsigned QW = $clog2(DRAIN_CYCLES + 1);
   localparam int unsigned WW = $clog2(WAKE_CYCLES + 1);

   cg_ctrl_state_e   state_q;
   cg_ctrl_state_e   state_d;
   logic [QW-1:0]    quiet_q;
   logic [QW-1:0]    quiet_d;
   logic [QW-1:0]    quiet_inc;
   logic [WW-1:0]    wake_q;
   logic [WW-1:0]    wake_d;
   logic [WW-1:0]    wake_inc;
   logic [CNT_W-1:0] sleep_q;
   logic             busy;
   logic             drain_done;
   logic             wake_done;
   logic             clock_en_q;
   logic             fetch_en_q;
   logic             core_sleep_q;

   assign busy       = if_busy_i | lsu_busy_i;
   assign quiet_inc  = quiet_q + QW'(1);
   assign wake_inc   = wake_q + WW'(1);
   assign drain_done = (quiet_inc == QW'(DRAIN_CYCLES));
   assign wake_done  = (wake_inc == WW'(WAKE_CYCLES));

   // Next-state logic; wake/abort in DRAIN deliberately beats drain completion.
   always_comb begin
      state_d = state_q;
      case (state_q)
         CG_BOOT: begin
            if (fetch_enable_i) begin
               state_d = CG_RUN;
            end
         end
         CG_RUN: begin
            if (wfi_req_i && !wake_i) begin
               state_d = CG_DRAIN;
            end
         end
         CG_DRAIN: begin
            if (wake_i || !wfi_req_i) begin
               state_d = CG_RUN;
            end else if (!busy && drain_done) begin
               state_d = CG_SLEEP;
            end
         end
         CG_SLEEP: begin
            if (wake_i) begin
               state_d = CG_WAKE;
            end
         end
         CG_WAKE: begin
            if (wake_done) begin
               state_d = CG_RUN;
            end
         end
         default: begin
            state_d = CG_BOOT;
         end
      endcase
   end

   // Quiet and wake counters restart from zero whenever their state is (re)entered.
   always_comb begin
      quiet_d = '0;
      wake_d  = '0;
      if (state_q == CG_DRAIN && !busy) begin
         quiet_d = quiet_inc;
      end
      if (state_q == CG_WAKE) begin
         wake_d = wake_inc;
      end
   end

   // State register plus output flops decoded from the next state, so outputs track the state edge.
   always_ff @(posedge clk_ungated_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= CG_BOOT;
         clock_en_q   <= 1'b0;
         core_sleep_q <= 1'b0;
         fetch_en_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         clock_en_q   <= (state_d == CG_RUN) || (state_d == CG_DRAIN) || (state_d == CG_WAKE);
         core_sleep_q <= (state_d == CG_SLEEP);
         fetch_en_q   <= fetch_en_q | ((state_q == CG_BOOT) & fetch_enable_i);
      end
   end

   // Quiet and wake counter registers.
   always_ff @(posedge clk_ungated_i or negedge rst_n) begin
      if (!rst_n) begin
         quiet_q <= '0;
         wake_q  <= '0;
      end else begin
         quiet_q <= quiet_d;
         wake_q  <= wake_d;
      end
   end

   // Saturating count of cycles the state register has held SLEEP; cleared only by reset.
   always_ff @(posedge clk_ungated_i or negedge rst_n) begin
      if (!rst_n) begin
         sleep_q <= '0;
      end else if (state_q == CG_SLEEP && sleep_q != {CNT_W{1'b1}}) begin
         sleep_q <= sleep_q + CNT_W'(1);
      end
   end

   assign clock_en_o     = clock_en_q;
   assign fetch_enable_o = fetch_en_q;
   assign core_sleep_o   = core_sleep_q;
   assign sleep_cycles_o = sleep_q;

endmodule

// File: tb/tb_cv32e40p_cg_ctrl.sv
// Self-checking bench for cv32e40p_cg_ctrl. Two instances share all inputs:
// the default one and one with a 4-bit sleep counter to exercise saturation.
module tb_cv32e40p_cg_ctrl;
   import cv32e40p_pkg::*;

   typedef struct {
      logic [4:0]     in;     // {fetch, wfi, wake, if_busy, lsu_busy}
      logic [2:0]     flags;  // {clock_en, fetch_en, core_sleep}
      cg_ctrl_state_e st;
      int             cnt;
   } step_t;

   logic        clk_ungated_i = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_enable_i = 1'b0;
   logic        wfi_req_i = 1'b0;
   logic        wake_i = 1'b0;
   logic        if_busy_i = 1'b0;
   logic        lsu_busy_i = 1'b0;
   logic        clock_en_o, fetch_enable_o, core_sleep_o;
   logic [31:0] sleep_cycles_o;
   logic        clock_en4, fetch_en4, core_sleep4;
   logic [3:0]  sleep_cycles4;

   int          vectors = 0;
   int          miscompares = 0;
   logic [44:0] exp_q[$];

   cv32e40p_cg_ctrl #(.DRAIN_CYCLES(2), .WAKE_CYCLES(1), .CNT_W(32)) dut (
      .clk_ungated_i (clk_ungated_i),
      .rst_n         (rst_n),
      .fetch_enable_i(fetch_enable_i),
      .wfi_req_i     (wfi_req_i),
      .wake_i        (wake_i),
      .if_busy_i     (if_busy_i),
      .lsu_busy_i    (lsu_busy_i),
      .clock_en_o    (clock_en_o),
      .fetch_enable_o(fetch_enable_o),
      .core_sleep_o  (core_sleep_o),
      .sleep_cycles_o(sleep_cycles_o)
   );

   cv32e40p_cg_ctrl #(.DRAIN_CYCLES(2), .WAKE_CYCLES(1), .CNT_W(4)) dut4 (
      .clk_ungated_i (clk_ungated_i),
      .rst_n         (rst_n),
      .fetch_enable_i(fetch_enable_i),
      .wfi_req_i     (wfi_req_i),
      .wake_i        (wake_i),
      .if_busy_i     (if_busy_i),
      .lsu_busy_i    (lsu_busy_i),
      .clock_en_o    (clock_en4),
      .fetch_enable_o(fetch_en4),
      .core_sleep_o  (core_sleep4),
      .sleep_cycles_o(sleep_cycles4)
   );

   // 10-unit ungated clock.
   always #5 clk_ungated_i = ~clk_ungated_i;

   // Advance one cycle and settle just after the rising edge.
   task automatic tick();
      @(posedge clk_ungated_i);
      #1;
   endtask

   function automatic step_t mk(logic [4:0] in, logic [2:0] flags, cg_ctrl_state_e st, int cnt);
      step_t s;
      s.in = in;
      s.flags = flags;
      s.st = st;
      s.cnt = cnt;
      return s;
   endfunction

   // Expected observation: both instances share flags; the 4-bit counter saturates at 15.
   function automatic logic [44:0] expect_of(step_t s);
      logic [3:0] c4;
      c4 = (s.cnt > 15) ? 4'd15 : 4'(s.cnt);
      return {s.flags, s.flags, 3'(s.st), 32'(s.cnt), c4};
   endfunction

   function automatic logic [44:0] observe();
      return {clock_en_o, fetch_enable_o, core_sleep_o,
              clock_en4, fetch_en4, core_sleep4,
              3'(dut.state_q), sleep_cycles_o, sleep_cycles4};
   endfunction

   // Plays a step table through the scoreboard: push expectation, clock, pop and compare.
   task automatic run_steps(string tag, step_t steps[$]);
      logic [44:0] got, want;
      foreach (steps[i]) begin
         {fetch_enable_i, wfi_req_i, wake_i, if_busy_i, lsu_busy_i} = steps[i].in;
         exp_q.push_back(expect_of(steps[i]));
         tick();
         got = observe();
         want = exp_q.pop_front();
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s[%0d]: got %h expected %h", tag, i, got, want);
         end
      end
   endtask

   task automatic test_reset();
      step_t s[$];
      logic [44:0] got;
      #3;
      got = observe();
      vectors++;
      if (got !== 45'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_values: got %h expected %h", got, 45'd0);
      end
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) s.push_back(mk(5'b00000, 3'b000, CG_BOOT, 0));
      for (int i = 0; i < 5; i++) s.push_back(mk(5'b10000, 3'b110, CG_RUN, 0));
      for (int i = 0; i < 3; i++) s.push_back(mk(5'b00000, 3'b110, CG_RUN, 0));
      run_steps("boot", s);
   endtask

   task automatic test_drain_busy();
      step_t s[$];
      for (int i = 0; i < 3; i++) s.push_back(mk(5'b01001, 3'b110, CG_DRAIN, 0));
      s.push_back(mk(5'b01000, 3'b110, CG_DRAIN, 0));
      s.push_back(mk(5'b01000, 3'b011, CG_SLEEP, 0));
      run_steps("drain_busy", s);
   endtask

   task automatic test_sleep_wake();
      step_t s[$];
      for (int k = 1; k <= 9; k++) s.push_back(mk(5'b00011, 3'b011, CG_SLEEP, k));
      s.push_back(mk(5'b00100, 3'b110, CG_WAKE, 10));
      s.push_back(mk(5'b01000, 3'b110, CG_RUN, 10));
      s.push_back(mk(5'b01000, 3'b110, CG_DRAIN, 10));
      s.push_back(mk(5'b00000, 3'b110, CG_RUN, 10));
      run_steps("sleep_wake", s);
   endtask

   task automatic test_drain_abort();
      step_t s[$];
      s.push_back(mk(5'b01100, 3'b110, CG_RUN, 10));
      s.push_back(mk(5'b01000, 3'b110, CG_DRAIN, 10));
      s.push_back(mk(5'b01000, 3'b110, CG_DRAIN, 10));
      s.push_back(mk(5'b01100, 3'b110, CG_RUN, 10));
      s.push_back(mk(5'b01000, 3'b110, CG_DRAIN, 10));
      s.push_back(mk(5'b00000, 3'b110, CG_RUN, 10));
      s.push_back(mk(5'b01000, 3'b110, CG_DRAIN, 10));
      s.push_back(mk(5'b01000, 3'b110, CG_DRAIN, 10));
      s.push_back(mk(5'b01010, 3'b110, CG_DRAIN, 10));
      s.push_back(mk(5'b01000, 3'b110, CG_DRAIN, 10));
      s.push_back(mk(5'b01000, 3'b011, CG_SLEEP, 10));
      run_steps("drain_abort", s);
   endtask

   task automatic test_saturate();
      step_t s[$];
      for (int k = 1; k <= 20; k++) s.push_back(mk(5'b01000, 3'b011, CG_SLEEP, 10 + k));
      run_steps("saturate", s);
   endtask

   task automatic test_reset_mid_sleep();
      step_t s[$];
      logic [44:0] got, want;
      want = {6'b0, 3'(CG_BOOT), 36'd0};
      #2;
      rst_n = 1'b0;
      #1;
      got = observe();
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("[TB] FAIL reset_mid_sleep: got %h expected %h", got, want);
      end
      tick();
      rst_n = 1'b1;
      {fetch_enable_i, wfi_req_i, wake_i, if_busy_i, lsu_busy_i} = 5'b00000;
      s.push_back(mk(5'b00000, 3'b000, CG_BOOT, 0));
      s.push_back(mk(5'b00100, 3'b000, CG_BOOT, 0));
      s.push_back(mk(5'b10000, 3'b110, CG_RUN, 0));
      run_steps("post_reset", s);
   endtask

   initial begin
      test_reset();
      test_drain_busy();
      test_sleep_wake();
      test_drain_abort();
      test_saturate();
      test_reset_mid_sleep();
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL scoreboard_drain: got %0d expected %0d", exp_q.size(), 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
